biriscv_csr_commit: RTL and testbench
=====================================

# biriscv_csr_commit

Writeback-side partner of the CSR unit. Accepts each instruction's E1 CSR result, early exception and PC, then carries it through E2 to WB. At E2 it merges late memory faults and interrupt launch. From WB it drives the `csr_writeback_*` bundle the CSR register file consumes. It also owns the post-exception flush state machine and the interrupt-inhibit handshake back to the CSR unit.

## Interface
Parameters:
- `SUPPORT_MMU`, default 1: when 0, `mem_exception_e2_i` page-fault codes are treated as 0.

Ports:
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset, asynchronous, active-low (already decided).
- `e1_valid_i`  in  1  instruction occupies E1 this cycle.
- `e1_pc_i`  in  32  PC of the E1 instruction.
- `e1_opcode_i`  in  32  opcode of the E1 instruction.
- `csr_result_e1_value_i`  in  32  CSR read value, or faulting opcode.
- `csr_result_e1_write_i`  in  1  CSR write requested.
- `csr_result_e1_wdata_i`  in  32  CSR write data.
- `csr_result_e1_exception_i`  in  6  early exception code.
- `squash_e1_i`  in  1  kill the E1 instruction (external redirect).
- `stall_i`  in  1  hold the E1 and E2 stages.
- `mem_exception_e2_i`  in  6  LSU fault code for the E2 instruction.
- `mem_addr_e2_i`  in  32  faulting data address.
- `take_interrupt_i`  in  1  CSR unit requests interrupt launch.
- `branch_csr_request_i`  in  1  CSR redirect issued (ends flush).
- `csr_writeback_write_o`  out  1  CSR write strobe.
- `csr_writeback_waddr_o`  out  12  CSR address (`opcode[31:20]`).
- `csr_writeback_wdata_o`  out  32  CSR write data.
- `csr_writeback_exception_o`  out  6  committed exception code.
- `csr_writeback_exception_pc_o`  out  32  PC of the excepting instruction.
- `csr_writeback_exception_addr_o`  out  32  tval value.
- `csr_rd_value_wb_o`  out  32  CSR read value for the RF write port.
- `flush_o`  out  1  discard younger instructions.
- `interrupt_inhibit_o`  out  1  block interrupt launch.

## Operation
- Pipeline: E1 inputs → E2 register → WB register. Every output except `flush_o`/`interrupt_inhibit_o` comes directly from WB flops.
- E1→E2 capture happens when `!stall_i`. An entry is valid iff `e1_valid_i && !squash_e1_i && state==RUN`.
- E2 exception priority, highest first:
  - interrupt (`take_interrupt_i` with E2 valid) → `EXCEPTION_INTERRUPT`;
  - nonzero E1 exception;
  - nonzero `mem_exception_e2_i`.
- `exception_addr`:
  - `ILLEGAL_INSTRUCTION` → E1 value (opcode);
  - memory fault → `mem_addr_e2_i`;
  - otherwise 0.
- CSR write is suppressed whenever the instruction carries any exception, except `EXCEPTION_FENCE`, where the write still commits.
- FSM states:
  - RUN → FLUSH when WB launches a nonzero exception.
  - FLUSH → RUN on `branch_csr_request_i`.
- In FLUSH: `flush_o=1`; E1/E2 are invalidated every cycle; no new entries are captured.
- `interrupt_inhibit_o` = FLUSH, OR E2/WB holds a CSR write or an exception.

## Timing
- Latency: `e1_valid_i` at cycle n → WB outputs valid at n+2 (with no stall).
- `stall_i` high: E2 holds its contents and WB loads a bubble. All write/exception outputs are therefore single-cycle pulses and never repeat.
- Reset values:
  - all outputs 0, state RUN;
  - `exception_pc`/`exception_addr`/`wdata` = 0.
- Reset mid-FLUSH: returns to RUN with empty stages.
- Exception at WB and a new E1 instruction in the same cycle: the E1 instruction is dropped, and so is the E2 instruction.
- `branch_csr_request_i` in RUN: ignored.
- `branch_csr_request_i` in the same cycle FLUSH is entered: stay in FLUSH. It only counts from the cycle after entry.
- `take_interrupt_i` while inhibited: ignored, i.e. no interrupt is tagged.
- `mem_exception_e2_i` is sampled only while E2 is valid and not stalled.

## Structure
- Shared package (`biriscv_defs`): `EXCEPTION_W`, all exception codes (`EXCEPTION_INTERRUPT`, `ILLEGAL_INSTRUCTION`, `FENCE`, page/access faults) and the FSM state encoding.
- One sub-module: `biriscv_csr_commit_stage`, a single parametrised valid/payload pipeline register with hold and kill. It is instantiated for both E2 and WB.

## Test plan
- **CSRRW commit:** `csrrw` with waddr 0x340, wdata 0xDEADBEEF at cycle n → `write_o=1`, `waddr=0x340`, `wdata=0xDEADBEEF` at n+2 for one cycle.
- **Illegal instruction:** E1 exception `ILLEGAL_INSTRUCTION`, value 0xFFFFFFFF, PC 0x80000010 → `exception=0x02`, `pc=0x80000010`, `addr=0xFFFFFFFF`, `write=0`; `flush_o` stays high until `branch_csr_request_i`.
- **Priority:** E2 carries E1 `EXCEPTION_ECALL` and a load fault (addr 0x1000) together → ECALL code committed, `addr=0`.
- **Interrupt:** `take_interrupt_i` while E2 holds a plain ALU op at PC 0x200 → `EXCEPTION_INTERRUPT`, `pc=0x200`. Asserted while E2 holds a CSR write → ignored, `interrupt_inhibit_o=1`.
- **Stall:** CSR write held 3 cycles in E2 → exactly one `write_o` pulse, emitted after the stall releases.
- **Reset mid-FLUSH:** `rst_ni` low during FLUSH → all outputs 0; `flush_o=0` the cycle after release.

Source files
------------

// File: rtl/biriscv_csr_commit_pkg.sv
// Shared definitions for the CSR commit path: exception codes, flush FSM
// encoding and the payload layouts carried by the E2 and WB registers.
package biriscv_defs;

  localparam int EXCEPTION_W = 6;

  localparam logic [EXCEPTION_W-1:0] EXCEPTION_NONE             = 6'h00;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_FETCH      = 6'h01;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h02;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_BREAKPOINT       = 6'h03;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_LOAD  = 6'h04;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_LOAD       = 6'h05;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_STORE = 6'h06;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_STORE      = 6'h07;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL            = 6'h08;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL_M          = 6'h0b;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_PAGE_FAULT_INST  = 6'h0c;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_PAGE_FAULT_LOAD  = 6'h0d;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_PAGE_FAULT_STORE = 6'h0f;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_FETCH = 6'h10;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_INTERRUPT        = 6'h20;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ERET             = 6'h30;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE            = 6'h31;

  typedef enum logic {
    STATE_RUN   = 1'b0,
    STATE_FLUSH = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [11:0]            waddr;
    logic [31:0]            value;
    logic                   write;
    logic [31:0]            wdata;
    logic [EXCEPTION_W-1:0] exception;
  } e2_entry_t;

  typedef struct packed {
    logic                   write;
    logic [11:0]            waddr;
    logic [31:0]            wdata;
    logic [EXCEPTION_W-1:0] exception;
    logic [31:0]            pc;
    logic [31:0]            addr;
    logic [31:0]            rd_value;
  } wb_entry_t;

  function automatic logic is_page_fault(input logic [EXCEPTION_W-1:0] code);
    return (code == EXCEPTION_PAGE_FAULT_INST) ||
           (code == EXCEPTION_PAGE_FAULT_LOAD) ||
           (code == EXCEPTION_PAGE_FAULT_STORE);
  endfunction

endpackage

// File: rtl/biriscv_csr_commit_stage.sv
// Valid/payload pipeline register with hold and kill. Payload is zeroed
// whenever the slot is empty so downstream outputs read 0 for bubbles.
module biriscv_csr_commit_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold,
  input  logic             kill,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  // Kill wins over hold so a flush empties a stalled slot too.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (kill) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (!hold) begin
      valid_reg <= in_valid;
      data_reg  <= in_valid ? in_data : '0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/biriscv_csr_commit.sv
// CSR commit path: carries E1 CSR results through E2 and WB, merges late
// memory faults and interrupts at E2, and runs the post-exception flush FSM.
module biriscv_csr_commit
  import biriscv_defs::*;
#(
  parameter int SUPPORT_MMU = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   e1_valid_i,
  input  logic [31:0]            e1_pc_i,
  input  logic [31:0]            e1_opcode_i,
  input  logic [31:0]            csr_result_e1_value_i,
  input  logic                   csr_result_e1_write_i,
  input  logic [31:0]            csr_result_e1_wdata_i,
  input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
  input  logic                   squash_e1_i,
  input  logic                   stall_i,
  input  logic [EXCEPTION_W-1:0] mem_exception_e2_i,
  input  logic [31:0]            mem_addr_e2_i,
  input  logic                   take_interrupt_i,
  input  logic                   branch_csr_request_i,
  output logic                   csr_writeback_write_o,
  output logic [11:0]            csr_writeback_waddr_o,
  output logic [31:0]            csr_writeback_wdata_o,
  output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
  output logic [31:0]            csr_writeback_exception_pc_o,
  output logic [31:0]            csr_writeback_exception_addr_o,
  output logic [31:0]            csr_rd_value_wb_o,
  output logic                   flush_o,
  output logic                   interrupt_inhibit_o
);

  commit_state_e state_reg;
  commit_state_e state_next;

  e2_entry_t              e2_in;
  e2_entry_t              e2_q;
  wb_entry_t              wb_in;
  wb_entry_t              wb_q;
  logic                   e2_valid;
  logic                   wb_valid;
  logic                   e1_accept;
  logic                   wb_in_valid;
  logic                   wb_exception_launch;
  logic                   pipe_kill;
  logic                   inhibit;
  logic                   take_int;
  logic [EXCEPTION_W-1:0] mem_exc;

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^e1_opcode_i[19:0];

  // A launching exception at WB kills E2 and the E1 capture in the same cycle.
  assign wb_exception_launch = wb_valid && (wb_q.exception != EXCEPTION_NONE);
  assign pipe_kill           = (state_reg == STATE_FLUSH) || wb_exception_launch;
  assign e1_accept           = e1_valid_i && !squash_e1_i && (state_reg == STATE_RUN);
  assign wb_in_valid         = e2_valid && !stall_i;

  always_comb begin
    e2_in           = '0;
    e2_in.pc        = e1_pc_i;
    e2_in.waddr     = e1_opcode_i[31:20];
    e2_in.value     = csr_result_e1_value_i;
    e2_in.write     = csr_result_e1_write_i;
    e2_in.wdata     = csr_result_e1_wdata_i;
    e2_in.exception = csr_result_e1_exception_i;
  end

  biriscv_csr_commit_stage #(
    .WIDTH($bits(e2_entry_t))
  ) u_e2 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .hold     (stall_i),
    .kill     (pipe_kill),
    .in_valid (e1_accept),
    .in_data  (e2_in),
    .out_valid(e2_valid),
    .out_data (e2_q)
  );

  assign inhibit = (state_reg == STATE_FLUSH) ||
                   (e2_valid && (e2_q.write || (e2_q.exception != EXCEPTION_NONE))) ||
                   (wb_valid && (wb_q.write || (wb_q.exception != EXCEPTION_NONE)));

  assign take_int = take_interrupt_i && e2_valid && !inhibit;

  always_comb begin
    mem_exc = mem_exception_e2_i;
    if ((SUPPORT_MMU == 0) && is_page_fault(mem_exception_e2_i)) begin
      mem_exc = EXCEPTION_NONE;
    end
  end

  // Merge point: interrupt over early exception over late memory fault.
  always_comb begin
    wb_in          = '0;
    wb_in.waddr    = e2_q.waddr;
    wb_in.wdata    = e2_q.wdata;
    wb_in.pc       = e2_q.pc;
    wb_in.rd_value = e2_q.value;
    if (take_int) begin
      wb_in.exception = EXCEPTION_INTERRUPT;
    end else if (e2_q.exception != EXCEPTION_NONE) begin
      wb_in.exception = e2_q.exception;
      if (e2_q.exception == EXCEPTION_ILLEGAL_INSTRUCTION) begin
        wb_in.addr = e2_q.value;
      end
    end else if (mem_exc != EXCEPTION_NONE) begin
      wb_in.exception = mem_exc;
      wb_in.addr      = mem_addr_e2_i;
    end
    wb_in.write = e2_q.write &&
                  ((wb_in.exception == EXCEPTION_NONE) || (wb_in.exception == EXCEPTION_FENCE));
  end

  biriscv_csr_commit_stage #(
    .WIDTH($bits(wb_entry_t))
  ) u_wb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .hold     (1'b0),
    .kill     (pipe_kill),
    .in_valid (wb_in_valid),
    .in_data  (wb_in),
    .out_valid(wb_valid),
    .out_data (wb_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= STATE_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // A redirect in the entry cycle is seen while still in RUN, so it is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      STATE_RUN:   if (wb_exception_launch) state_next = STATE_FLUSH;
      STATE_FLUSH: if (branch_csr_request_i) state_next = STATE_RUN;
      default:     state_next = STATE_RUN;
    endcase
  end

  assign csr_writeback_write_o          = wb_q.write;
  assign csr_writeback_waddr_o          = wb_q.waddr;
  assign csr_writeback_wdata_o          = wb_q.wdata;
  assign csr_writeback_exception_o      = wb_q.exception;
  assign csr_writeback_exception_pc_o   = wb_q.pc;
  assign csr_writeback_exception_addr_o = wb_q.addr;
  assign csr_rd_value_wb_o              = wb_q.rd_value;
  assign flush_o                        = (state_reg == STATE_FLUSH);
  assign interrupt_inhibit_o            = inhibit;

endmodule

// File: tb/tb_biriscv_csr_commit.sv
// Directed bench for biriscv_csr_commit: commit, exceptions, priority,
// interrupts, stall and reset during flush, with hand-computed expectations.
module tb_biriscv_csr_commit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        e1_valid_i;
  logic [31:0] e1_pc_i;
  logic [31:0] e1_opcode_i;
  logic [31:0] csr_result_e1_value_i;
  logic        csr_result_e1_write_i;
  logic [31:0] csr_result_e1_wdata_i;
  logic [5:0]  csr_result_e1_exception_i;
  logic        squash_e1_i;
  logic        stall_i;
  logic [5:0]  mem_exception_e2_i;
  logic [31:0] mem_addr_e2_i;
  logic        take_interrupt_i;
  logic        branch_csr_request_i;
  logic        csr_writeback_write_o;
  logic [11:0] csr_writeback_waddr_o;
  logic [31:0] csr_writeback_wdata_o;
  logic [5:0]  csr_writeback_exception_o;
  logic [31:0] csr_writeback_exception_pc_o;
  logic [31:0] csr_writeback_exception_addr_o;
  logic [31:0] csr_rd_value_wb_o;
  logic        flush_o;
  logic        interrupt_inhibit_o;

  int checks = 0;
  int errors = 0;

  biriscv_csr_commit #(.SUPPORT_MMU(1)) dut (
    .clk_i                         (clk_i),
    .rst_ni                        (rst_ni),
    .e1_valid_i                    (e1_valid_i),
    .e1_pc_i                       (e1_pc_i),
    .e1_opcode_i                   (e1_opcode_i),
    .csr_result_e1_value_i         (csr_result_e1_value_i),
    .csr_result_e1_write_i         (csr_result_e1_write_i),
    .csr_result_e1_wdata_i         (csr_result_e1_wdata_i),
    .csr_result_e1_exception_i     (csr_result_e1_exception_i),
    .squash_e1_i                   (squash_e1_i),
    .stall_i                       (stall_i),
    .mem_exception_e2_i            (mem_exception_e2_i),
    .mem_addr_e2_i                 (mem_addr_e2_i),
    .take_interrupt_i              (take_interrupt_i),
    .branch_csr_request_i          (branch_csr_request_i),
    .csr_writeback_write_o         (csr_writeback_write_o),
    .csr_writeback_waddr_o         (csr_writeback_waddr_o),
    .csr_writeback_wdata_o         (csr_writeback_wdata_o),
    .csr_writeback_exception_o     (csr_writeback_exception_o),
    .csr_writeback_exception_pc_o  (csr_writeback_exception_pc_o),
    .csr_writeback_exception_addr_o(csr_writeback_exception_addr_o),
    .csr_rd_value_wb_o             (csr_rd_value_wb_o),
    .flush_o                       (flush_o),
    .interrupt_inhibit_o           (interrupt_inhibit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_e1();
    e1_valid_i = 0; e1_pc_i = 0; e1_opcode_i = 0;
    csr_result_e1_value_i = 0; csr_result_e1_write_i = 0;
    csr_result_e1_wdata_i = 0; csr_result_e1_exception_i = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] op, input logic [31:0] val,
                       input logic wr, input logic [31:0] wd, input logic [5:0] exc);
    e1_valid_i = 1; e1_pc_i = pc; e1_opcode_i = op;
    csr_result_e1_value_i = val; csr_result_e1_write_i = wr;
    csr_result_e1_wdata_i = wd; csr_result_e1_exception_i = exc;
  endtask

  task automatic leave_flush();
    branch_csr_request_i = 1;
    step();
    branch_csr_request_i = 0;
  endtask

  initial begin
    rst_ni = 0; clear_e1();
    squash_e1_i = 0; stall_i = 0; mem_exception_e2_i = 0; mem_addr_e2_i = 0;
    take_interrupt_i = 0; branch_csr_request_i = 0;
    step(); step();
    chk("rst_write", csr_writeback_write_o, 0);
    chk("rst_exc", csr_writeback_exception_o, 0);
    chk("rst_pc", csr_writeback_exception_pc_o, 0);
    chk("rst_wdata", csr_writeback_wdata_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_inhibit", interrupt_inhibit_o, 0);
    rst_ni = 1;
    step();
    $display("txn reset done");

    // CSRRW x2, mscratch(0x340), x1
    issue(32'h100, 32'h34009173, 32'h11111111, 1, 32'hDEADBEEF, 6'h00);
    step(); clear_e1();
    chk("csrrw_inhibit_e2", interrupt_inhibit_o, 1);
    chk("csrrw_write_early", csr_writeback_write_o, 0);
    step();
    chk("csrrw_write", csr_writeback_write_o, 1);
    chk("csrrw_waddr", csr_writeback_waddr_o, 32'h340);
    chk("csrrw_wdata", csr_writeback_wdata_o, 32'hDEADBEEF);
    chk("csrrw_rd", csr_rd_value_wb_o, 32'h11111111);
    chk("csrrw_exc", csr_writeback_exception_o, 0);
    step();
    chk("csrrw_pulse", csr_writeback_write_o, 0);
    chk("csrrw_inhibit_clr", interrupt_inhibit_o, 0);
    $display("txn csrrw commit");

    // Illegal instruction followed by two younger instructions that must be dropped
    issue(32'h80000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h1234, 6'h02);
    step();
    issue(32'h104, 32'h34009173, 32'h0, 1, 32'hAAAA0001, 6'h00);
    step();
    chk("ill_exc", csr_writeback_exception_o, 32'h02);
    chk("ill_pc", csr_writeback_exception_pc_o, 32'h80000010);
    chk("ill_addr", csr_writeback_exception_addr_o, 32'hFFFFFFFF);
    chk("ill_write", csr_writeback_write_o, 0);
    chk("ill_flush_pre", flush_o, 0);
    issue(32'h108, 32'h34009173, 32'h0, 1, 32'hAAAA0002, 6'h00);
    branch_csr_request_i = 1;
    step();
    branch_csr_request_i = 0;
    chk("ill_flush", flush_o, 1);
    chk("ill_drop_e2", csr_writeback_write_o, 0);
    chk("ill_exc_clr", csr_writeback_exception_o, 0);
    issue(32'h10c, 32'h34009173, 32'h0, 1, 32'hAAAA0003, 6'h00);
    step(); clear_e1();
    chk("ill_drop_e1", csr_writeback_write_o, 0);
    chk("ill_flush_hold", flush_o, 1);
    step();
    chk("ill_drop_flush", csr_writeback_write_o, 0);
    chk("ill_flush_hold2", flush_o, 1);
    leave_flush();
    chk("ill_flush_end", flush_o, 0);
    chk("ill_inhibit_end", interrupt_inhibit_o, 0);
    $display("txn illegal instruction");

    // ECALL in E1 beats a load fault arriving at E2
    issue(32'h300, 32'h00000073, 32'h0, 0, 32'h0, 6'h08);
    step(); clear_e1();
    mem_exception_e2_i = 6'h05; mem_addr_e2_i = 32'h1000;
    step();
    mem_exception_e2_i = 0; mem_addr_e2_i = 0;
    chk("prio_exc", csr_writeback_exception_o, 32'h08);
    chk("prio_addr", csr_writeback_exception_addr_o, 0);
    chk("prio_pc", csr_writeback_exception_pc_o, 32'h300);
    step();
    chk("prio_flush", flush_o, 1);
    leave_flush();
    chk("prio_flush_end", flush_o, 0);
    $display("txn ecall priority");

    // Store fault alone reports the data address
    issue(32'h400, 32'h00112023, 32'h0, 0, 32'h0, 6'h00);
    step(); clear_e1();
    mem_exception_e2_i = 6'h07; mem_addr_e2_i = 32'h2004;
    step();
    mem_exception_e2_i = 0; mem_addr_e2_i = 0;
    chk("mem_exc", csr_writeback_exception_o, 32'h07);
    chk("mem_addr", csr_writeback_exception_addr_o, 32'h2004);
    chk("mem_pc", csr_writeback_exception_pc_o, 32'h400);
    step();
    leave_flush();
    $display("txn store fault");

    // Interrupt on a plain ALU op
    issue(32'h200, 32'h00208033, 32'h0, 0, 32'h0, 6'h00);
    step(); clear_e1();
    take_interrupt_i = 1;
    chk("int_inhibit_low", interrupt_inhibit_o, 0);
    step();
    take_interrupt_i = 0;
    chk("int_exc", csr_writeback_exception_o, 32'h20);
    chk("int_pc", csr_writeback_exception_pc_o, 32'h200);
    chk("int_addr", csr_writeback_exception_addr_o, 0);
    chk("int_write", csr_writeback_write_o, 0);
    step();
    chk("int_flush", flush_o, 1);
    leave_flush();
    $display("txn interrupt launch");

    // Interrupt request while E2 holds a CSR write is ignored
    issue(32'h210, 32'h34009173, 32'h0, 1, 32'h55, 6'h00);
    step(); clear_e1();
    take_interrupt_i = 1;
    chk("intblk_inhibit", interrupt_inhibit_o, 1);
    step();
    take_interrupt_i = 0;
    chk("intblk_exc", csr_writeback_exception_o, 0);
    chk("intblk_write", csr_writeback_write_o, 1);
    chk("intblk_wdata", csr_writeback_wdata_o, 32'h55);
    step();
    chk("intblk_flush", flush_o, 0);
    $display("txn interrupt inhibited");

    // CSR write stalled three cycles in E2
    issue(32'h220, 32'h34109173, 32'h0, 1, 32'hCAFEF00D, 6'h00);
    step(); clear_e1();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_write", csr_writeback_write_o, 0);
    end
    stall_i = 0;
    step();
    chk("stall_write", csr_writeback_write_o, 1);
    chk("stall_waddr", csr_writeback_waddr_o, 32'h341);
    chk("stall_wdata", csr_writeback_wdata_o, 32'hCAFEF00D);
    step();
    chk("stall_pulse", csr_writeback_write_o, 0);
    $display("txn stalled csr write");

    // Reset asserted while in FLUSH
    issue(32'h500, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 6'h02);
    step(); clear_e1();
    step();
    step();
    chk("rf_flush", flush_o, 1);
    rst_ni = 0;
    #1;
    chk("rf_flush_rst", flush_o, 0);
    chk("rf_exc_rst", csr_writeback_exception_o, 0);
    chk("rf_pc_rst", csr_writeback_exception_pc_o, 0);
    chk("rf_inhibit_rst", interrupt_inhibit_o, 0);
    step();
    rst_ni = 1;
    step();
    chk("rf_flush_after", flush_o, 0);
    chk("rf_write_after", csr_writeback_write_o, 0);
    $display("txn reset during flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
